active_list: RTL
================

// Module: active_list
// PURPOSE
//  In-order active list (reorder buffer) downstream of the register map table.
//  On each rename it records {logical reg, previous physical reg, new physical reg}.
//  At in-order commit it returns the previous physical reg to the free list.
//  On flush it walks back from the youngest entry so the map table and free list can be restored.
// PARAMETERS
//  DEPTH   16  number of entries; power of two, >=2
//  IDX_W    4  log2(DEPTH); entry tag width
//  PREG_W   6  physical register index width (64 physical regs)
//  LREG_W   5  logical register index width (32 MIPS regs)
// PORTS
//  clk               in   1       clock; all state updates on rising edge
//  rst               in   1       synchronous, active-high reset
//  alloc_valid       in   1       renamed instruction with uses_rw=1 presented
//  alloc_ready       out  1       entry available; alloc fires when valid&ready
//  alloc_lreg        in   LREG_W  destination logical reg (prev_logical_reg)
//  alloc_prev_preg   in   PREG_W  previous mapping (prev_physical_reg)
//  alloc_new_preg    in   PREG_W  newly assigned physical reg
//  alloc_idx         out  IDX_W   tag of the entry written on a firing alloc (= tail)
//  complete_valid    in   1       writeback done for an entry
//  complete_idx      in   IDX_W   tag of the completed entry
//  flush             in   1       squash all uncommitted entries
//  commit_valid      out  1       head entry retires this cycle
//  commit_lreg       out  LREG_W  retiring logical reg
//  free_valid        out  1       free_register valid (=commit_valid)
//  free_register     out  PREG_W  prev_preg of the retiring entry, to the free list
//  rollback_valid    out  1       one squashed entry presented this cycle
//  rollback_lreg     out  LREG_W  map table index to restore
//  rollback_prev_preg out PREG_W  value to write back into the map table
//  rollback_new_preg out  PREG_W  physical reg to return to the free list
//  count             out  IDX_W+1 occupied entries, 0..DEPTH
//  empty             out  1       count==0
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all done bits=0, state=NORMAL.
//    All valid outputs=0, data outputs=0, alloc_ready=1, empty=1.
//  - Storage is a circular buffer; head/tail wrap from DEPTH-1 to 0.
//    The full/empty distinction comes from count, never from head==tail alone.
//  - FSM NORMAL: alloc_ready = (count<DEPTH) & !flush.
//    A firing alloc writes the entry at tail, clears its done bit, advances tail; visible next cycle.
//  - Completion: complete_valid sets done[complete_idx] if that entry is occupied.
//    It is ignored for unoccupied entries and while in ROLLBACK.
//  - Commit (NORMAL only): commit_valid = !empty & done[head], driven combinationally from registered state.
//    There is no backpressure; head advances on the same edge.
//    Completion to commit latency is 1 cycle minimum; at most one commit per cycle.
//  - Same-cycle alloc+commit: both fire and count is unchanged. At count==DEPTH alloc_ready=0,
//    even if a commit occurs that cycle.
//  - Same-cycle complete of head entry: it commits the following cycle, not the same cycle.
//  - flush in NORMAL: any commit presented that cycle still retires; the alloc that cycle is blocked.
//    Next state is ROLLBACK if the remaining count>0, else NORMAL.
//  - ROLLBACK: each cycle rollback_valid=1 for entry tail-1; tail decrements, count decrements.
//    alloc_ready=0, commit_valid=0, and flush is ignored.
//    Return to NORMAL on the edge that pops the last entry; rollback_valid=0 thereafter.
//    Entries are presented youngest first, so restoring each prev_preg leaves the oldest mapping.
//  - Done bits of popped entries are cleared.
//  - rst asserted at any time, including mid-ROLLBACK, returns to reset state on the next edge.
//    Partially rolled-back entries are discarded.
// TESTING
//  1 Reset, alloc 3 entries (lreg 1/2/3, prev 1/2/3, new 32/33/34) -> alloc_idx 0,1,2; count=3; no commit.
//  2 Complete idx 1 then idx 0 -> commit idx0 (free_register=1) the cycle after idx0 completes,
//    then idx1 (free_register=2) the next cycle; idx2 is held.
//  3 Fill 16 entries -> alloc_ready=0 at count=16; commit head with alloc_valid high -> no alloc that cycle.
//    Run 20 alloc/commit pairs -> tail wraps 15->0, count stable.
//  4 3 entries outstanding, flush -> ROLLBACK for 3 cycles presenting idx 2,1,0
//    (new_preg 34,33,32; prev 3,2,1); then NORMAL, count=0, alloc_ready=1.
//  5 Flush in the same cycle head commits -> commit retires; remaining entries roll back;
//    complete_valid and flush during ROLLBACK have no effect.
//  6 rst pulsed mid-ROLLBACK -> next cycle count=0, rollback_valid=0, alloc_ready=1.
//    Complete to an unoccupied idx -> no commit.

Source files
------------

// File: rtl/active_list_if.sv
// Rename / completion / commit / rollback bundle for the in-order active list.
// master: rename and writeback side driving the list; slave: the active list.
interface active_list_if #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6,
    parameter int LREG_W = 5
) ();
    logic              alloc_valid;
    logic              alloc_ready;
    logic [LREG_W-1:0] alloc_lreg;
    logic [PREG_W-1:0] alloc_prev_preg;
    logic [PREG_W-1:0] alloc_new_preg;
    logic [IDX_W-1:0]  alloc_idx;
    logic              complete_valid;
    logic [IDX_W-1:0]  complete_idx;
    logic              flush;
    logic              commit_valid;
    logic [LREG_W-1:0] commit_lreg;
    logic              free_valid;
    logic [PREG_W-1:0] free_register;
    logic              rollback_valid;
    logic [LREG_W-1:0] rollback_lreg;
    logic [PREG_W-1:0] rollback_prev_preg;
    logic [PREG_W-1:0] rollback_new_preg;
    logic [IDX_W:0]    count;
    logic              empty;

    modport master (
        output alloc_valid, alloc_lreg, alloc_prev_preg, alloc_new_preg,
        output complete_valid, complete_idx, flush,
        input  alloc_ready, alloc_idx,
        input  commit_valid, commit_lreg, free_valid, free_register,
        input  rollback_valid, rollback_lreg, rollback_prev_preg, rollback_new_preg,
        input  count, empty
    );

    modport slave (
        input  alloc_valid, alloc_lreg, alloc_prev_preg, alloc_new_preg,
        input  complete_valid, complete_idx, flush,
        output alloc_ready, alloc_idx,
        output commit_valid, commit_lreg, free_valid, free_register,
        output rollback_valid, rollback_lreg, rollback_prev_preg, rollback_new_preg,
        output count, empty
    );
endinterface

// File: rtl/active_list.sv
// In-order active list behind the register map table.
// Each rename records {lreg, previous preg, new preg} at the tail. The head
// retires in order once its writeback is done and hands the previous preg back
// to the free list. A flush walks the list back from the youngest entry, one
// entry per cycle, so the map table and free list can be restored.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_NORMAL   | accepting allocs, completions and in-order commits
// ST_ROLLBACK | popping entry tail-1 every cycle until the list is empty
module active_list #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6,
    parameter int LREG_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    active_list_if.slave bus
);
    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_ROLLBACK = 1'b1
    } state_t;

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] ONE_CNT  = (IDX_W+1)'(1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   head_q, head_d;
    logic [IDX_W-1:0]   tail_q, tail_d;
    logic [IDX_W:0]     count_q, count_d;
    logic [DEPTH-1:0]   done_q, done_d;

    // entry payload; only ever read behind a valid, so it needs no reset
    logic [LREG_W-1:0]  lreg_mem [DEPTH];
    logic [PREG_W-1:0]  prev_mem [DEPTH];
    logic [PREG_W-1:0]  new_mem  [DEPTH];

    logic               commit_fire;
    logic               alloc_ok;
    logic               alloc_fire;
    logic [IDX_W-1:0]   tail_m1;
    logic [IDX_W-1:0]   complete_off;
    logic               complete_hit;

    // handshake decisions taken from registered state plus this cycle's inputs
    always_comb begin
        commit_fire  = (state_q == ST_NORMAL) && (count_q != '0) && done_q[head_q];
        // a commit in the same cycle does not free a slot for a full list
        alloc_ok     = (state_q == ST_NORMAL) && (count_q < FULL_CNT) && !bus.flush;
        alloc_fire   = bus.alloc_valid && alloc_ok;
        tail_m1      = tail_q - 1'b1;
        // entry is occupied when its distance from head is below count
        complete_off = bus.complete_idx - head_q;
        complete_hit = bus.complete_valid && ({1'b0, complete_off} < count_q);
    end

    // next-state for pointers, occupancy, done bits and the flush walk
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        done_d  = done_q;
        case (state_q)
            ST_NORMAL: begin
                // set first so the clears of retiring/new entries take priority
                if (complete_hit) begin
                    done_d[bus.complete_idx] = 1'b1;
                end
                if (commit_fire) begin
                    done_d[head_q] = 1'b0;
                    head_d         = head_q + 1'b1;
                end
                if (alloc_fire) begin
                    done_d[tail_q] = 1'b0;
                    tail_d         = tail_q + 1'b1;
                end
                count_d = count_q + {{IDX_W{1'b0}}, alloc_fire}
                                  - {{IDX_W{1'b0}}, commit_fire};
                // flush blocks the alloc, so count_d is what is left to unwind
                if (bus.flush && (count_d != '0)) begin
                    state_d = ST_ROLLBACK;
                end
            end
            ST_ROLLBACK: begin
                if (count_q != '0) begin
                    done_d[tail_m1] = 1'b0;
                    tail_d          = tail_m1;
                    count_d         = count_q - ONE_CNT;
                end
                if (count_q <= ONE_CNT) begin
                    state_d = ST_NORMAL;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    // control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_NORMAL;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // payload write at the tail on a firing alloc
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            lreg_mem[tail_q] <= bus.alloc_lreg;
            prev_mem[tail_q] <= bus.alloc_prev_preg;
            new_mem[tail_q]  <= bus.alloc_new_preg;
        end
    end

    assign bus.alloc_ready        = alloc_ok;
    assign bus.alloc_idx          = tail_q;
    assign bus.commit_valid       = commit_fire;
    assign bus.commit_lreg        = commit_fire ? lreg_mem[head_q] : '0;
    assign bus.free_valid         = commit_fire;
    assign bus.free_register      = commit_fire ? prev_mem[head_q] : '0;
    assign bus.rollback_valid     = (state_q == ST_ROLLBACK);
    assign bus.rollback_lreg      = (state_q == ST_ROLLBACK) ? lreg_mem[tail_m1] : '0;
    assign bus.rollback_prev_preg = (state_q == ST_ROLLBACK) ? prev_mem[tail_m1] : '0;
    assign bus.rollback_new_preg  = (state_q == ST_ROLLBACK) ? new_mem[tail_m1]  : '0;
    assign bus.count              = count_q;
    assign bus.empty              = (count_q == '0);
endmodule
